// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, fixed-latency memory between a fetch (read-only)
//   requester and a data (load/store) requester. Data normally wins; a
//   starvation counter forces a fetch win after STARVE_LIMIT consecutive data
//   wins while fetch waits. Read data is routed back to its issuer through a
//   tag pipe that mirrors the memory latency, so returns keep issue order.
//   A test setup-write path takes the memory over once in-flight reads drain.
//
// Ports
//   clock, reset            core clock, asynchronous active-low reset
//   f_req/f_addr            fetch read request (held until f_gnt)
//   f_gnt                   fetch accepted this cycle (combinational)
//   f_rvalid/f_rdata        fetch read return
//   d_req/d_we/d_addr/
//   d_wdata/d_be            data request (held until d_gnt)
//   d_gnt                   data accepted this cycle (combinational)
//   d_rvalid/d_rdata        data read return
//   setup_write/
//   setup_address/
//   setup_data_in           test setup-write request and payload
//   mem_ready               memory accepts an issue this cycle
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be        memory issue
//   mem_rdata               memory read data, MEM_LATENCY cycles after issue
//   arb_state               0 = RUN, 1 = DRAIN, 2 = SETUP
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                f_req,
  input  logic [ADDR_W-1:0]   f_addr,
  output logic                f_gnt,
  output logic                f_rvalid,
  output logic [DATA_W-1:0]   f_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  input  logic                setup_write,
  input  logic [ADDR_W-1:0]   setup_address,
  input  logic [DATA_W-1:0]   setup_data_in,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [1:0]          arb_state
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SETUP = 2'd2
  } state_t;

  state_t                 state_r;
  logic [CNT_W-1:0]       starve_cnt_r;
  // Tag pipe: index 0 is the newest issue, MEM_LATENCY-1 lines up with mem_rdata.
  logic [MEM_LATENCY-1:0] pipe_valid_r;
  logic [MEM_LATENCY-1:0] pipe_owner_r;   // 1 = data, 0 = fetch

  logic f_win_s;
  logic d_win_s;
  logic grant_ok_s;
  logic issue_read_s;
  logic pipe_busy_s;

  // Grants are only possible in RUN with the memory ready; reset low gates
  // them off so nothing reaches the memory while the block is held in reset.
  assign grant_ok_s   = reset && (state_r == ST_RUN) && mem_ready;
  assign f_gnt        = grant_ok_s && f_win_s;
  assign d_gnt        = grant_ok_s && d_win_s;
  assign issue_read_s = f_gnt || (d_gnt && !d_we);
  assign pipe_busy_s  = |pipe_valid_r;

  assign f_rvalid  = pipe_valid_r[MEM_LATENCY-1] && !pipe_owner_r[MEM_LATENCY-1];
  assign d_rvalid  = pipe_valid_r[MEM_LATENCY-1] &&  pipe_owner_r[MEM_LATENCY-1];
  assign f_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign arb_state = state_r;

  // Winner selection: data first unless fetch has been starved to the limit.
  always_comb begin
    f_win_s = 1'b0;
    d_win_s = 1'b0;
    if (f_req && (starve_cnt_r == STARVE_MAX)) begin
      f_win_s = 1'b1;
    end else if (d_req) begin
      d_win_s = 1'b1;
    end else if (f_req) begin
      f_win_s = 1'b1;
    end else begin
      f_win_s = 1'b0;
      d_win_s = 1'b0;
    end
  end

  // Memory issue mux: setup path owns the port in SETUP, otherwise the winner.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = f_addr;
    mem_wdata = {DATA_W{1'b0}};
    mem_be    = {BE_W{1'b1}};
    if (!reset) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end else if (state_r == ST_SETUP) begin
      mem_req   = setup_write;
      mem_we    = 1'b1;
      mem_addr  = setup_address;
      mem_wdata = setup_data_in;
      mem_be    = {BE_W{1'b1}};
    end else if (d_gnt) begin
      mem_req   = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end else if (f_gnt) begin
      mem_req   = 1'b1;
      mem_we    = 1'b0;
      mem_addr  = f_addr;
    end else begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

  // Starvation counter: counts data wins while fetch is kept waiting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (f_gnt || !f_req) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (d_gnt && (starve_cnt_r != STARVE_MAX)) begin
      starve_cnt_r <= starve_cnt_r + CNT_ONE;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Tag pipe: shifts every cycle; only reads create a valid entry, so writes
  // occupy a slot without ever producing a return pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pipe_valid_r <= {MEM_LATENCY{1'b0}};
      pipe_owner_r <= {MEM_LATENCY{1'b0}};
    end else begin
      pipe_valid_r[0] <= issue_read_s;
      pipe_owner_r[0] <= d_gnt;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipe_valid_r[i] <= pipe_valid_r[i-1];
        pipe_owner_r[i] <= pipe_owner_r[i-1];
      end
    end
  end

  // Mode FSM: setup only takes the memory once no read is still in flight;
  // dropping setup_write while draining simply resumes normal arbitration.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (setup_write) begin
            state_r <= pipe_busy_s ? ST_DRAIN : ST_SETUP;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (!setup_write) begin
            state_r <= ST_RUN;
          end else if (!pipe_busy_s) begin
            state_r <= ST_SETUP;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_SETUP: begin
          if (!setup_write) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_SETUP;
          end
        end
        default: begin
          state_r <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter (MEM_LATENCY=2, STARVE_LIMIT=4).
// A transaction-level model (a queue of outstanding returns with due cycles,
// a word memory, a mode and a starvation count) predicts every output each
// cycle; directed sequences pin the model with literal expectations, then a
// long randomized run is checked against the same model.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int LAT = 2;
  localparam int LIM = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt, f_rvalid;
  logic [DW-1:0] f_rdata;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_be;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          setup_write;
  logic [AW-1:0] setup_address;
  logic [DW-1:0] setup_data_in;
  logic          mem_ready, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    arb_state;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIM)
  ) dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .setup_write(setup_write), .setup_address(setup_address), .setup_data_in(setup_data_in),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .arb_state(arb_state)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    int          due;
    logic        own;   // 1 = data
    logic [31:0] data;
  } ret_t;

  ret_t        q[$];
  logic [31:0] mem [256];
  int          mode;
  int          cnt;
  int          cyc;
  int          checks;
  int          failures;

  logic        cap_fg, cap_dg, cap_fv, cap_dv, cap_req, cap_we;
  logic [3:0]  cap_be;
  logic [31:0] cap_frd, cap_drd;
  logic [1:0]  cap_state;
  logic        e_fg;
  logic [11:0] dpat, fpat;
  logic        any_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  // One cycle of the reference model: predict, compare, then advance.
  task automatic model_cycle();
    logic fg, dg, fv, dv, ereq, ewe;
    logic [31:0] rd;
    logic [31:0] ea;
    bit busy;
    int idx;
    cap_fg = f_gnt; cap_dg = d_gnt; cap_fv = f_rvalid; cap_dv = d_rvalid;
    cap_req = mem_req; cap_we = mem_we; cap_be = mem_be;
    cap_frd = f_rdata; cap_drd = d_rdata; cap_state = arb_state;
    fg = 1'b0; dg = 1'b0; fv = 1'b0; dv = 1'b0; ereq = 1'b0; ewe = 1'b0; rd = 32'd0;
    if (!reset) begin
      q.delete();
      mode = 0;
      cnt  = 0;
    end else begin
      if (mode == 0 && mem_ready) begin
        if (f_req && cnt == LIM) fg = 1'b1;
        else if (d_req)          dg = 1'b1;
        else if (f_req)          fg = 1'b1;
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        if (q[0].own) dv = 1'b1; else fv = 1'b1;
        rd = q[0].data;
      end
      if (mode == 2) begin
        ereq = setup_write;
        ewe  = 1'b1;
      end else begin
        ereq = fg | dg;
        ewe  = dg & d_we;
      end
    end
    chk("f_gnt", f_gnt, fg);
    chk("d_gnt", d_gnt, dg);
    chk("f_rvalid", f_rvalid, fv);
    chk("d_rvalid", d_rvalid, dv);
    chk("mem_req", mem_req, ereq);
    chk("mem_we", mem_we, ewe);
    chk("arb_state", arb_state, mode);
    if (ereq) begin
      ea = (mode == 2) ? setup_address : (dg ? d_addr : f_addr);
      chk("mem_addr", mem_addr, ea);
      if (ewe) begin
        chk("mem_wdata", mem_wdata, (mode == 2) ? setup_data_in : d_wdata);
        chk("mem_be", mem_be, (mode == 2) ? 4'hF : d_be);
      end
    end
    if (fv) chk("f_rdata", f_rdata, rd);
    if (dv) chk("d_rdata", d_rdata, rd);
    e_fg = fg;
    if (reset) begin
      busy = (q.size() > 0);
      if (fv || dv) void'(q.pop_front());
      if (fg || (dg && !d_we)) begin
        idx = fg ? int'(f_addr[9:2]) : int'(d_addr[9:2]);
        q.push_back('{due: cyc + LAT, own: dg, data: mem[idx]});
      end
      if (dg && d_we) begin
        idx = int'(d_addr[9:2]);
        for (int b = 0; b < 4; b++) if (d_be[b]) mem[idx][8*b +: 8] = d_wdata[8*b +: 8];
      end
      if (mode == 2 && setup_write) mem[int'(setup_address[9:2])] = setup_data_in;
      case (mode)
        0: if (setup_write) mode = busy ? 1 : 2;
        1: if (!setup_write) mode = 0; else if (!busy) mode = 2;
        2: if (!setup_write) mode = 0;
        default: mode = 0;
      endcase
      if (fg || !f_req) cnt = 0;
      else if (dg) cnt = (cnt < LIM) ? cnt + 1 : LIM;
    end
  endtask

  // Check at the falling edge, then move to just after the next rising edge
  // and present the memory return due in the new cycle.
  task automatic step();
    @(negedge clock);
    model_cycle();
    @(posedge clock);
    #1;
    cyc++;
    if (q.size() > 0 && q[0].due == cyc) mem_rdata = q[0].data;
    else mem_rdata = $urandom;
  endtask

  task automatic randomize_inputs();
    if (!(f_req && !e_fg)) begin
      f_req  = ($urandom_range(0, 9) < 6);
      f_addr = 32'($urandom_range(0, 255)) << 2;
    end
    if (!(d_req && !cap_dg)) begin
      d_req   = ($urandom_range(0, 9) < 5);
      d_we    = ($urandom_range(0, 9) < 4);
      d_addr  = 32'($urandom_range(0, 255)) << 2;
      d_wdata = $urandom;
      d_be    = 4'($urandom_range(1, 15));
    end
    mem_ready = ($urandom_range(0, 9) < 8);
    if (setup_write) setup_write = ($urandom_range(0, 7) != 0);
    else             setup_write = ($urandom_range(0, 39) == 0);
    setup_address = 32'($urandom_range(0, 255)) << 2;
    setup_data_in = $urandom;
  endtask

  initial begin
    checks = 0; failures = 0; mode = 0; cnt = 0; cyc = 0; e_fg = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    reset = 1'b0; f_req = 1'b0; f_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'd0; d_wdata = 32'd0; d_be = 4'd0; setup_write = 1'b0;
    setup_address = 32'd0; setup_data_in = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;

    repeat (2) step();
    chk("reset_state", cap_state, 2'd0);
    chk("reset_req", cap_req, 1'b0);
    reset = 1'b1;
    mem_ready = 1'b1;

    // Full-word write, then a partial write with byte enables 0011.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_be = 4'hF;
    step();
    chk("wr_full_gnt", cap_dg, 1'b1);
    d_addr = 32'h40; d_wdata = 32'h1234; d_be = 4'b0011;
    step();
    chk("wr_gnt", cap_dg, 1'b1);
    chk("wr_we", cap_we, 1'b1);
    chk("wr_be", cap_be, 4'b0011);
    d_req = 1'b0;
    any_v = 1'b0;
    repeat (3) begin step(); any_v = any_v | cap_dv | cap_fv; end
    chk("wr_no_rvalid", any_v, 1'b0);

    // Fetch read: granted same cycle, data back two cycles later.
    f_req = 1'b1; f_addr = 32'h100;
    step();
    chk("f_gnt_same_cycle", cap_fg, 1'b1);
    f_req = 1'b0;
    step();
    chk("f_rvalid_not_early", cap_fv, 1'b0);
    step();
    chk("f_rvalid_lat", cap_fv, 1'b1);
    chk("f_rdata_val", cap_frd, 32'hDEADBEEF);
    chk("d_rvalid_quiet", cap_dv, 1'b0);

    // Both request continuously; mem_ready drops once at i=7.
    f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    for (int i = 0; i < 12; i++) begin
      mem_ready = (i != 7);
      step();
      dpat[i] = cap_dg;
      fpat[i] = cap_fg;
    end
    chk("starve_d_pattern", dpat, 12'b101101101111);
    chk("starve_f_pattern", fpat, 12'b010000010000);
    mem_ready = 1'b1; f_req = 1'b0; d_req = 1'b0;
    repeat (3) step();

    // Two reads in flight, then setup: drain two cycles, SETUP, back to RUN.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    step();
    chk("s_d_gnt", cap_dg, 1'b1);
    d_req = 1'b0; f_req = 1'b1; f_addr = 32'h100;
    step();
    chk("s_f_gnt", cap_fg, 1'b1);
    f_req = 1'b0; setup_write = 1'b1; setup_address = 32'h80; setup_data_in = 32'hCAFEF00D;
    step();
    chk("s_state_run", cap_state, 2'd0);
    chk("s_d_rvalid", cap_dv, 1'b1);
    chk("s_d_rdata", cap_drd, 32'h00001234);
    f_req = 1'b1;
    step();
    chk("s_state_drain1", cap_state, 2'd1);
    chk("s_f_rvalid", cap_fv, 1'b1);
    chk("s_drain_no_gnt", cap_fg, 1'b0);
    step();
    chk("s_state_drain2", cap_state, 2'd1);
    step();
    chk("s_state_setup", cap_state, 2'd2);
    chk("s_setup_req", cap_req, 1'b1);
    chk("s_setup_we", cap_we, 1'b1);
    chk("s_setup_be", cap_be, 4'hF);
    chk("s_setup_no_gnt", cap_fg, 1'b0);
    setup_write = 1'b0;
    step();
    chk("s_setup_hold", cap_state, 2'd2);
    step();
    chk("s_back_run", cap_state, 2'd0);
    chk("s_run_f_gnt", cap_fg, 1'b1);
    f_req = 1'b0;
    repeat (2) step();

    // Reset with a read in flight: no return afterwards.
    d_req = 1'b1; d_we = 1'b0;
    step();
    d_req = 1'b0; reset = 1'b0;
    step();
    chk("rst_state", cap_state, 2'd0);
    chk("rst_no_rvalid", cap_dv, 1'b0);
    step();
    reset = 1'b1;
    any_v = 1'b0;
    repeat (4) begin step(); any_v = any_v | cap_dv | cap_fv; end
    chk("rst_dropped_read", any_v, 1'b0);

    // Randomized traffic with one reset pulse in the middle.
    for (int i = 0; i < 4000; i++) begin
      randomize_inputs();
      reset = !(i >= 2000 && i < 2003);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
